tea_data_regs: RTL
==================

Name: tea_data_regs

Overview:
- Sits directly downstream/upstream of the TEA UART front end, between it and the TEA cipher core.
- Assembles the received byte stream into a 128-bit key and a 64-bit plaintext block.
- Starts the core once both are complete and drives the front end's calculate level.
- Captures the 64-bit ciphertext and serialises it back to the front end as 8 paced byte strobes for UART transmit.

Parameters:
- BYTE_GAP_CYCLES, 1042: clocks between successive o_tx_byte_valid pulses; must be ≥ one full UART frame at the front-end baud rate.
- TIMEOUT_CYCLES, 65535: cipher wait limit; used only when TEA_TIMEOUT_EN is defined.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_key_byte  in  8  key byte from front end
- i_key_byte_valid  in  1  one-cycle strobe for i_key_byte
- i_plain_byte  in  8  plaintext byte from front end
- i_plain_byte_valid  in  1  one-cycle strobe for i_plain_byte
- i_cipher  in  64  ciphertext from core
- i_cipher_valid  in  1  one-cycle strobe from core, cipher done
- o_key  out  128  assembled key to core
- o_plain  out  64  assembled plaintext to core
- o_start  out  1  one-cycle start pulse to core
- o_calculate  out  1  level to front end; high while a calculation or transmit is in progress
- o_tx_byte  out  8  ciphertext byte to front end
- o_tx_byte_valid  out  1  one-cycle strobe for o_tx_byte
- o_key_loaded  out  1  all 16 key bytes received
- o_timeout  out  1  sticky timeout flag; tied 0 when TEA_TIMEOUT_EN is not defined

Behaviour:
- Clocking/reset: one clock (i_clk); reset i_rst is synchronous, active-high.
- Reset values: all outputs 0; key_cnt=0, plain_cnt=0, plain_ready=0; state=IDLE.
- Byte order: big-endian shift-in. Each accepted byte does reg <= {reg[N-9:0], byte}, so the first byte ends up in the MSBs.
- Key path, accepted only when o_calculate=0:
  - Each byte increments key_cnt (4 bits).
  - The byte with key_cnt=0 clears o_key_loaded.
  - The 16th byte (key_cnt=15) sets o_key_loaded and wraps key_cnt to 0.
- Plain path, accepted only when o_calculate=0:
  - Each byte increments plain_cnt (3 bits).
  - The byte with plain_cnt=0 clears plain_ready.
  - The 8th byte sets plain_ready and wraps plain_cnt to 0.
- Strobes arriving while o_calculate=1 are dropped: no register, counter or flag change.
- Key and plain strobes in the same cycle are both accepted independently.
- State machine:
  - IDLE: when plain_ready & o_key_loaded, go to START. The earliest transition is the cycle after the completing byte's registers update.
  - START: o_start=1 for exactly one cycle; o_calculate=1 from this cycle on. Next state WAIT.
  - WAIT: hold o_key/o_plain stable. On i_cipher_valid, latch i_cipher into cipher_q and go to SEND with idx=0, gap=0. i_cipher_valid is ignored in every other state.
  - SEND:
    - When gap==0, drive o_tx_byte=cipher_q[63-8*idx -: 8] with o_tx_byte_valid=1 for one cycle, then reload gap=BYTE_GAP_CYCLES-1; otherwise decrement gap.
    - After idx 7 is sent, wait a further BYTE_GAP_CYCLES.
    - Then clear plain_ready, drop o_calculate and go to IDLE.
    - o_key_loaded is retained, so a new 8-byte plaintext alone triggers the next run.
- Latency:
  - o_start asserts 2 cycles after the completing byte strobe.
  - The first o_tx_byte_valid asserts 1 cycle after i_cipher_valid.
  - Bytes are spaced exactly BYTE_GAP_CYCLES apart.
- o_tx_byte holds its last value between strobes.
- Reset mid-operation, in any state: on the next edge, all counters, flags, key/plain/cipher registers and outputs return to their reset values. A partially sent ciphertext is abandoned.

Optional Feature:
- Macro: TEA_TIMEOUT_EN.
- Defined:
  - A wait counter starts at 0 on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES without i_cipher_valid, go to IDLE, clear plain_ready, drop o_calculate and set o_timeout.
  - o_timeout clears on reset or on the next START.
- Not defined: no counter is built; WAIT waits indefinitely; o_timeout is constant 0.

Test Plan:
- Reset check: assert i_rst for 2 cycles mid-SEND -> all outputs 0 the next cycle; no further o_tx_byte_valid.
- Key load: 16 key bytes 0x00..0x0F -> o_key=0x000102030405060708090A0B0C0D0E0F; o_key_loaded rises after the 16th byte; no o_start.
- Full run: key all-zero, then plain bytes 0x00 ×8 -> o_start exactly 2 cycles after the 8th strobe. Inject i_cipher=0x41EA3A0A94BAA940 -> bytes 41,EA,3A,0A,94,BA,A9,40 at BYTE_GAP_CYCLES spacing; o_calculate falls BYTE_GAP_CYCLES after the last byte.
- Gating: plain/key strobes with value 0xFF during WAIT -> o_key, o_plain and counters unchanged; a second i_cipher_valid during SEND is ignored.
- Plain before key: 8 plain bytes, then 16 key bytes -> o_start fires only after the 16th key byte. A re-key (1 byte of a new key) clears o_key_loaded.
- TEA_TIMEOUT_EN, TIMEOUT_CYCLES=100: no i_cipher_valid -> o_calculate falls and o_timeout=1 after 100 WAIT cycles; the next run clears o_timeout at START.

Source files
------------

// File: rtl/tea_data_regs.sv
// tea_data_regs -- byte-level glue between the TEA UART front end and the
// TEA cipher core.
//
// Purpose:
//   Collects key bytes into a 128-bit key and plaintext bytes into a 64-bit
//   block. Both are shifted in big-endian, so the first byte ends up in the
//   MSBs. Once both are complete the block pulses o_start to the core and
//   raises o_calculate. It then waits for the core's ciphertext. The
//   ciphertext is returned to the front end as 8 byte strobes, spaced
//   BYTE_GAP_CYCLES apart. One further gap follows the last byte, and then
//   o_calculate drops again.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_key_byte/_valid                 key byte stream from the front end
//   i_plain_byte/_valid               plaintext byte stream from the front end
//   i_cipher/_valid                   ciphertext and done strobe from the core
//   o_key, o_plain, o_start           operands and start pulse to the core
//   o_calculate                       busy level to the front end
//   o_tx_byte/_valid                  ciphertext bytes back to the front end
//   o_key_loaded                      all 16 key bytes present
//   o_timeout                         sticky cipher-wait timeout flag
//
// Build option:
//   TEA_TIMEOUT_EN  When this macro is defined, WAIT gives up after
//                   TIMEOUT_CYCLES and sets o_timeout. When it is not
//                   defined, WAIT waits forever and o_timeout is held at 0.
module tea_data_regs #(
  parameter int unsigned BYTE_GAP_CYCLES = 1042,
  parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [7:0]   i_key_byte,
  input  logic         i_key_byte_valid,
  input  logic [7:0]   i_plain_byte,
  input  logic         i_plain_byte_valid,
  input  logic [63:0]  i_cipher,
  input  logic         i_cipher_valid,
  output logic [127:0] o_key,
  output logic [63:0]  o_plain,
  output logic         o_start,
  output logic         o_calculate,
  output logic [7:0]   o_tx_byte,
  output logic         o_tx_byte_valid,
  output logic         o_key_loaded,
  output logic         o_timeout
);

  localparam int unsigned GAP_W = (BYTE_GAP_CYCLES > 1) ? $clog2(BYTE_GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(BYTE_GAP_CYCLES - 32'd1);
  localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(32'd1);
  localparam logic [GAP_W-1:0] GAP_ZERO   = GAP_W'(32'd0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SEND  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [63:0]    plain_q, plain_d;
  logic [63:0]    cipher_q, cipher_d;
  logic [3:0]     key_cnt_q, key_cnt_d;
  logic [2:0]     plain_cnt_q, plain_cnt_d;
  logic           plain_ready_q, plain_ready_d;
  logic           key_loaded_q, key_loaded_d;
  logic [3:0]     sent_q, sent_d;        // ciphertext bytes already emitted (0..8)
  logic [GAP_W-1:0] gap_q, gap_d;
  logic           start_q, start_d;
  logic           calc_q, calc_d;
  logic [7:0]     tx_byte_q, tx_byte_d;
  logic           tx_valid_q, tx_valid_d;
  logic           key_acc_s, plain_acc_s;

`ifdef TEA_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 32'd1);
  logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Byte assembly, FSM next state and the next value of every registered output.
  always_comb begin
    key_acc_s     = i_key_byte_valid & ~calc_q;
    plain_acc_s   = i_plain_byte_valid & ~calc_q;
    state_d       = state_q;
    key_d         = key_q;
    plain_d       = plain_q;
    cipher_d      = cipher_q;
    key_cnt_d     = key_cnt_q;
    plain_cnt_d   = plain_cnt_q;
    plain_ready_d = plain_ready_q;
    key_loaded_d  = key_loaded_q;
    sent_d        = sent_q;
    gap_d         = gap_q;
    start_d       = 1'b0;
    calc_d        = calc_q;
    tx_byte_d     = tx_byte_q;
    tx_valid_d    = 1'b0;
`ifdef TEA_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    timeout_d     = timeout_q;
`endif

    // The 4-bit counter wraps from 15 to 0 by itself.
    if (key_acc_s) begin
      key_d     = {key_q[119:0], i_key_byte};
      key_cnt_d = key_cnt_q + 4'd1;
      if (key_cnt_q == 4'd15) begin
        key_loaded_d = 1'b1;
      end else if (key_cnt_q == 4'd0) begin
        key_loaded_d = 1'b0;
      end else begin
        key_loaded_d = key_loaded_q;
      end
    end else begin
      key_d = key_q;
    end

    if (plain_acc_s) begin
      plain_d     = {plain_q[55:0], i_plain_byte};
      plain_cnt_d = plain_cnt_q + 3'd1;
      if (plain_cnt_q == 3'd7) begin
        plain_ready_d = 1'b1;
      end else if (plain_cnt_q == 3'd0) begin
        plain_ready_d = 1'b0;
      end else begin
        plain_ready_d = plain_ready_q;
      end
    end else begin
      plain_d = plain_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (plain_ready_q & key_loaded_q) begin
          state_d = ST_START;
          start_d = 1'b1;
          calc_d  = 1'b1;
`ifdef TEA_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
`ifdef TEA_TIMEOUT_EN
        wait_cnt_d = {TMO_W{1'b0}};
`endif
      end
      ST_WAIT: begin
        // Byte 0 is emitted on the capture edge so that it appears in the
        // cycle right after i_cipher_valid.
        if (i_cipher_valid) begin
          cipher_d   = i_cipher;
          tx_byte_d  = i_cipher[63:56];
          tx_valid_d = 1'b1;
          sent_d     = 4'd1;
          gap_d      = GAP_RELOAD;
          state_d    = ST_SEND;
        end else begin
`ifdef TEA_TIMEOUT_EN
          if (wait_cnt_q == TMO_LAST) begin
            state_d       = ST_IDLE;
            plain_ready_d = 1'b0;
            calc_d        = 1'b0;
            timeout_d     = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + TMO_W'(32'd1);
          end
`else
          state_d = ST_WAIT;
`endif
        end
      end
      ST_SEND: begin
        // Once all 8 bytes are out, the trailing gap expires and the run ends.
        if (gap_q == GAP_ZERO) begin
          if (sent_q == 4'd8) begin
            state_d       = ST_IDLE;
            plain_ready_d = 1'b0;
            calc_d        = 1'b0;
            sent_d        = 4'd0;
          end else begin
            tx_byte_d  = cipher_q[6'd63 - {sent_q[2:0], 3'b000} -: 8];
            tx_valid_d = 1'b1;
            sent_d     = sent_q + 4'd1;
            gap_d      = GAP_RELOAD;
          end
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      key_q         <= 128'd0;
      plain_q       <= 64'd0;
      cipher_q      <= 64'd0;
      key_cnt_q     <= 4'd0;
      plain_cnt_q   <= 3'd0;
      plain_ready_q <= 1'b0;
      key_loaded_q  <= 1'b0;
      sent_q        <= 4'd0;
      gap_q         <= GAP_ZERO;
      start_q       <= 1'b0;
      calc_q        <= 1'b0;
      tx_byte_q     <= 8'd0;
      tx_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_q         <= key_d;
      plain_q       <= plain_d;
      cipher_q      <= cipher_d;
      key_cnt_q     <= key_cnt_d;
      plain_cnt_q   <= plain_cnt_d;
      plain_ready_q <= plain_ready_d;
      key_loaded_q  <= key_loaded_d;
      sent_q        <= sent_d;
      gap_q         <= gap_d;
      start_q       <= start_d;
      calc_q        <= calc_d;
      tx_byte_q     <= tx_byte_d;
      tx_valid_q    <= tx_valid_d;
    end
  end

`ifdef TEA_TIMEOUT_EN
  // Cipher-wait counter and sticky timeout flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wait_cnt_q <= {TMO_W{1'b0}};
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  // No timeout hardware. The comparison keeps TIMEOUT_CYCLES referenced in
  // this build, and both of its outcomes give 0.
  assign o_timeout = (TIMEOUT_CYCLES == 32'd0) ? 1'b0 : 1'b0;
`endif

  assign o_key           = key_q;
  assign o_plain         = plain_q;
  assign o_start         = start_q;
  assign o_calculate     = calc_q;
  assign o_tx_byte       = tx_byte_q;
  assign o_tx_byte_valid = tx_valid_q;
  assign o_key_loaded    = key_loaded_q;

endmodule
